// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundle between the memory stage and its target.
interface dbus_sram_responder_if;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } dbus_resp_t;

  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);

endinterface

// File: rtl/dbus_sram_responder.sv
// Single-outstanding data-bus target backed by a word-addressed SRAM with
// configurable address-accept and data-return latency.
module dbus_sram_responder #(
  parameter int unsigned MEM_WORDS  = 1024,
  parameter int unsigned ADDR_DELAY = 0,
  parameter int unsigned DATA_DELAY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  dbus_sram_responder_if.slave          bus
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ADDR_WAIT = 2'd1,
    S_DATA_WAIT = 2'd2,
    S_RESP      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        rdata_q, rdata_d;
  logic [31:0]        data_q, data_d;
  logic [31:0]        mem_q [MEM_WORDS];

  logic               addr_ok_c;
  logic               accept_c;
  logic               is_wr_c;
  logic               mem_we_c;
  logic [IDX_W-1:0]   idx_c;
  logic [31:0]        resp_word_c;
  logic               unused_c;

  assign idx_c       = bus.dreq.addr[IDX_W+1:2];
  assign is_wr_c     = (bus.dreq.strobe != 4'd0);
  assign resp_word_c = is_wr_c ? 32'd0 : mem_q[idx_c];
  assign mem_we_c    = accept_c & is_wr_c & ~reset;
  assign unused_c    = ^{bus.dreq.size, bus.dreq.addr[31:IDX_W+2], bus.dreq.addr[1:0]};

  // addr_ok is combinational; data_ok decodes the registered RESP state
  assign bus.dresp = {addr_ok_c, (state_q == S_RESP), data_q};

  // Next-state, counters and response capture
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdata_d   = rdata_q;
    data_d    = data_q;
    addr_ok_c = 1'b0;
    accept_c  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.dreq.valid) begin
          if (ADDR_DELAY == 0) begin
            addr_ok_c = 1'b1;
            accept_c  = 1'b1;
          end else begin
            state_d = S_ADDR_WAIT;
            cnt_d   = CNT_W'(ADDR_DELAY - 1);
          end
        end
      end
      S_ADDR_WAIT: begin
        if (!bus.dreq.valid) begin
          // requester withdrew: drop the request without touching memory
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          addr_ok_c = 1'b1;
          accept_c  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          data_d  = rdata_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Acceptance: snapshot the response word; DATA_DELAY=1 skips DATA_WAIT
    if (accept_c) begin
      rdata_d = resp_word_c;
      if (DATA_DELAY <= 1) begin
        state_d = S_RESP;
        cnt_d   = '0;
        data_d  = resp_word_c;
      end else begin
        state_d = S_DATA_WAIT;
        cnt_d   = CNT_W'(DATA_DELAY - 2);
      end
    end
  end

  // Control and response registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      data_q  <= data_d;
    end
  end

  // SRAM byte-lane write port; contents survive reset
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      for (int i = 0; i < 4; i++) begin
        if (bus.dreq.strobe[i]) begin
          mem_q[idx_c][8*i +: 8] <= bus.dreq.data[8*i +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed bench: default-latency instance driven from a vector table,
// delayed instance (ADDR_DELAY=3, DATA_DELAY=2) driven by hand sequences.
module tb_dbus_sram_responder;

  logic clk;
  logic rst0;
  logic rst1;

  int checks;
  int errors;

  dbus_sram_responder_if bus0();
  dbus_sram_responder_if bus1();

  dbus_sram_responder #(.MEM_WORDS(1024), .ADDR_DELAY(0), .DATA_DELAY(1)) u0 (
    .clk(clk), .reset(rst0), .bus(bus0)
  );

  dbus_sram_responder #(.MEM_WORDS(1024), .ADDR_DELAY(3), .DATA_DELAY(2)) u1 (
    .clk(clk), .reset(rst1), .bus(bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] wdata;
    logic        ao;
    logic        dok;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus0.dreq.valid  = v;
    bus0.dreq.addr   = a;
    bus0.dreq.size   = 3'd2;
    bus0.dreq.strobe = s;
    bus0.dreq.data   = d;
  endtask

  task automatic drive1(input logic v, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
    bus1.dreq.valid  = v;
    bus1.dreq.addr   = a;
    bus1.dreq.size   = 3'd2;
    bus1.dreq.strobe = s;
    bus1.dreq.data   = d;
  endtask

  // One cycle on the delayed instance: drive at negedge, check 1 ns later
  task automatic cyc1(input string name, input logic v, input logic [31:0] a, input logic [3:0] s,
                      input logic [31:0] d, input logic exp_ao, input logic exp_dok);
    @(negedge clk);
    drive1(v, a, s, d);
    #1;
    chk({name, " addr_ok"}, 32'(bus1.dresp.addr_ok), 32'(exp_ao));
    chk({name, " data_ok"}, 32'(bus1.dresp.data_ok), 32'(exp_dok));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    drive0(1'b0, 32'h0, 4'h0, 32'h0);
    drive1(1'b0, 32'h0, 4'h0, 32'h0);

    // {valid, addr, strobe, wdata, exp addr_ok, exp data_ok, exp data}
    vecs[0]  = '{1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[2]  = '{1'b1, 32'h10,   4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 32'h20,   4'hF, 32'h11223344, 1'b1, 1'b0, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 32'h20,   4'h2, 32'h0000AA00, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h23,   4'h0, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[8]  = '{1'b1, 32'h23,   4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h1122AA44};
    vecs[10] = '{1'b1, 32'h1000, 4'hF, 32'hCAFEF00D, 1'b1, 1'b0, 32'h1122AA44};
    vecs[11] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h0};
    vecs[12] = '{1'b1, 32'h0,    4'h0, 32'h0,        1'b1, 1'b0, 32'h0};
    vecs[13] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D};
    vecs[14] = '{1'b1, 32'h10,   4'h0, 32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
    vecs[15] = '{1'b1, 32'h20,   4'h0, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[16] = '{1'b1, 32'h20,   4'h0, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
    vecs[17] = '{1'b0, 32'h0,    4'h0, 32'h0,        1'b0, 1'b1, 32'h1122AA44};

    repeat (2) @(negedge clk);
    rst0 = 1'b0;
    rst1 = 1'b0;
    #1;
    chk("reset u0 addr_ok", 32'(bus0.dresp.addr_ok), 32'h0);
    chk("reset u0 data_ok", 32'(bus0.dresp.data_ok), 32'h0);
    chk("reset u0 data",    bus0.dresp.data,         32'h0);
    chk("reset u1 addr_ok", 32'(bus1.dresp.addr_ok), 32'h0);
    chk("reset u1 data_ok", 32'(bus1.dresp.data_ok), 32'h0);
    chk("reset u1 data",    bus1.dresp.data,         32'h0);

    // Default-latency instance: table of per-cycle vectors
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      drive0(vecs[i].v, vecs[i].addr, vecs[i].strb, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d addr_ok", i), 32'(bus0.dresp.addr_ok), 32'(vecs[i].ao));
      chk($sformatf("vec%0d data_ok", i), 32'(bus0.dresp.data_ok), 32'(vecs[i].dok));
      chk($sformatf("vec%0d data", i),    bus0.dresp.data,         vecs[i].rdata);
    end
    @(negedge clk);
    drive0(1'b0, 32'h0, 4'h0, 32'h0);

    // Delayed instance: write 0x30, valid held c0..c5 -> addr_ok c3, data_ok c5
    for (int c = 0; c < 6; c++) begin
      cyc1($sformatf("dly wr c%0d", c), 1'b1, 32'h30, 4'hF, 32'h5A5A1234, c == 3, c == 5);
      if (c == 5) chk("dly wr resp data", bus1.dresp.data, 32'h0);
    end
    cyc1("dly wr c6", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);

    // Abort (valid c0..c1), then a read restarting in c3 -> addr_ok c6, data_ok c8
    for (int c = 0; c < 10; c++) begin
      if (c < 2)
        cyc1($sformatf("abort c%0d", c), 1'b1, 32'h30, 4'hF, 32'hFFFFFFFF, 1'b0, 1'b0);
      else if (c >= 3 && c <= 6)
        cyc1($sformatf("restart c%0d", c), 1'b1, 32'h30, 4'h0, 32'h0, c == 6, 1'b0);
      else
        cyc1($sformatf("restart c%0d", c), 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, c == 8);
      if (c == 8) chk("abort read data", bus1.dresp.data, 32'h5A5A1234);
    end

    // Reset while the read sits in DATA_WAIT
    for (int c = 0; c < 4; c++)
      cyc1($sformatf("rst rd c%0d", c), 1'b1, 32'h30, 4'h0, 32'h0, c == 3, 1'b0);
    cyc1("rst rd c4", 1'b0, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
    chk("rst rd held data", bus1.dresp.data, 32'h5A5A1234);
    rst1 = 1'b1;
    #1;
    chk("rst mid data_ok", 32'(bus1.dresp.data_ok), 32'h0);
    chk("rst mid data",    bus1.dresp.data,         32'h0);
    @(negedge clk);
    rst1 = 1'b0;
    for (int c = 0; c < 7; c++) begin
      cyc1($sformatf("post rst c%0d", c), c < 4, 32'h30, 4'h0, 32'h0, c == 3, c == 5);
      if (c == 5) chk("post rst data", bus1.dresp.data, 32'h5A5A1234);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
